rocketcpu_sample_fifo: RTL and testbench

ROCKETCPU_SAMPLE_FIFO -- requirements
Module: rocketcpu_sample_fifo

---
 rtl/rocketcpu_sample_fifo_pkg.sv | 25 ++
 rtl/rocketcpu_sample_fifo_sync_fifo.sv | 86 ++++++++
 rtl/rocketcpu_sample_fifo.sv | 139 +++++++++++++
 tb/tb_rocketcpu_sample_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rocketcpu_sample_fifo_pkg.sv
// Shared definitions for the sample FIFO: register map, STATUS/CTRL bit layout
// and reset values.
package rocketcpu_sample_fifo_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    // STATUS flag positions are offsets above the level field, whose width
    // depends on DEPTH.
    localparam int ST_FULL_OFS  = 0;
    localparam int ST_EMPTY_OFS = 1;
    localparam int ST_UNDER_OFS = 2;
    localparam int ST_OVER_OFS  = 3;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;
    localparam int CTRL_WM_LSB    = 8;

    localparam logic [7:0] WM_RESET = 8'd4;

endpackage

// File: rtl/rocketcpu_sample_fifo_sync_fifo.sv
// Synchronous FIFO storage with flush and a registered read port that can
// also be forced to zero when the consumer asks for a sample it cannot have.
module rocketcpu_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             rd_zero,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wptr_r;
    logic [AW-1:0]    rptr_r;
    logic [LW-1:0]    level_r;
    logic [WIDTH-1:0] rd_data_r;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Occupancy flags and qualified push/pop; flush overrides both.
    always_comb begin
        full_s    = (level_r == LW'(DEPTH));
        empty_s   = (level_r == LW'(0));
        push_ok_s = push & ~full_s & ~flush;
        pop_ok_s  = pop & ~empty_s & ~flush;
    end

    // Storage array; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wptr_r] <= push_data;
        end
    end

    // Pointers and level, wrapping naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            level_r <= '0;
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Registered read port; a flush leaves the presented word untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= '0;
        end else if (flush) begin
            rd_data_r <= rd_data_r;
        end else if (pop_ok_s) begin
            rd_data_r <= mem_r[rptr_r];
        end else if (rd_zero) begin
            rd_data_r <= '0;
        end
    end

    assign full    = full_s;
    assign empty   = empty_s;
    assign level   = level_r;
    assign rd_data = rd_data_r;

endmodule

// File: rtl/rocketcpu_sample_fifo.sv
// Bus-attached audio sample FIFO: the CPU pushes PCM words over the bus, the
// audio path pops one per sample period; sticky error flags and a level IRQ.
module rocketcpu_sample_fifo
    import rocketcpu_sample_fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             i_wb_clk,
    input  logic             reset,
    input  logic [31:0]      i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic [3:0]       i_wb_sel,
    input  logic             i_wb_we,
    input  logic             i_wb_cyc,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack,
    input  logic             i_sample_req,
    output logic [WIDTH-1:0] o_sample,
    output logic             o_irq
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic             ack_r;
    logic [31:0]      rdt_r;
    logic             enable_r;
    logic [7:0]       watermark_r;
    logic             underrun_r;
    logic             overrun_r;

    reg_sel_e         reg_sel_s;
    logic             bus_wr_s;
    logic             data_wr_s;
    logic             status_wr_s;
    logic             ctrl_wr_s;
    logic             flush_s;
    logic             sreq_s;
    logic             pop_s;
    logic             rd_zero_s;
    logic             full_s;
    logic             empty_s;
    logic [LW-1:0]    level_s;
    logic [8:0]       level_ext_s;
    logic [31:0]      status_s;
    logic [31:0]      ctrl_rd_s;
    logic [31:0]      rd_mux_s;
    logic             unused_s;

    assign unused_s = ^{i_wb_sel, i_wb_adr, i_wb_dat};

    // Register decode; writes take effect at the end of the ack cycle.
    always_comb begin
        reg_sel_s   = reg_sel_e'(i_wb_adr[3:2]);
        bus_wr_s    = i_wb_cyc & i_wb_we & ack_r;
        data_wr_s   = bus_wr_s & (reg_sel_s == REG_DATA);
        status_wr_s = bus_wr_s & (reg_sel_s == REG_STATUS);
        ctrl_wr_s   = bus_wr_s & (reg_sel_s == REG_CTRL);
        flush_s     = ctrl_wr_s & i_wb_dat[CTRL_FLUSH_BIT];
        sreq_s      = i_sample_req & ~flush_s;
        pop_s       = sreq_s & enable_r;
        rd_zero_s   = sreq_s & (~enable_r | empty_s);
    end

    // Readback images of STATUS and CTRL, plus the read data mux.
    always_comb begin
        status_s                     = 32'd0;
        status_s[LW-1:0]             = level_s;
        status_s[LW + ST_FULL_OFS]   = full_s;
        status_s[LW + ST_EMPTY_OFS]  = empty_s;
        status_s[LW + ST_UNDER_OFS]  = underrun_r;
        status_s[LW + ST_OVER_OFS]   = overrun_r;
        ctrl_rd_s                    = 32'd0;
        ctrl_rd_s[CTRL_EN_BIT]       = enable_r;
        ctrl_rd_s[CTRL_WM_LSB +: 8]  = watermark_r;
        case (reg_sel_s)
            REG_STATUS: rd_mux_s = status_s;
            REG_CTRL:   rd_mux_s = ctrl_rd_s;
            default:    rd_mux_s = 32'd0;
        endcase
    end

    // Single-cycle ack and read data captured as the ack rises.
    always_ff @(posedge i_wb_clk) begin
        if (reset) begin
            ack_r <= 1'b0;
            rdt_r <= 32'd0;
        end else begin
            ack_r <= i_wb_cyc & ~ack_r;
            if (i_wb_cyc && !ack_r && !i_wb_we) begin
                rdt_r <= rd_mux_s;
            end else begin
                rdt_r <= 32'd0;
            end
        end
    end

    // Control register and sticky flags; a new error wins over a same-cycle clear.
    always_ff @(posedge i_wb_clk) begin
        if (reset) begin
            enable_r    <= 1'b0;
            watermark_r <= WM_RESET;
            underrun_r  <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                enable_r    <= i_wb_dat[CTRL_EN_BIT];
                watermark_r <= i_wb_dat[CTRL_WM_LSB +: 8];
            end
            underrun_r <= (underrun_r & ~(status_wr_s & i_wb_dat[LW + ST_UNDER_OFS]))
                        | (pop_s & empty_s);
            overrun_r  <= (overrun_r & ~(status_wr_s & i_wb_dat[LW + ST_OVER_OFS]))
                        | (data_wr_s & full_s);
        end
    end

    rocketcpu_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_wb_clk),
        .reset     (reset),
        .push      (data_wr_s),
        .push_data (i_wb_dat[WIDTH-1:0]),
        .pop       (pop_s),
        .rd_zero   (rd_zero_s),
        .flush     (flush_s),
        .full      (full_s),
        .empty     (empty_s),
        .level     (level_s),
        .rd_data   (o_sample)
    );

    assign level_ext_s = 9'(level_s);
    assign o_irq       = enable_r & (level_ext_s <= {1'b0, watermark_r});
    assign o_wb_ack    = ack_r;
    assign o_wb_rdt    = rdt_r;

endmodule

// File: tb/tb_rocketcpu_sample_fifo.sv
// Scoreboard bench for rocketcpu_sample_fifo: stimulus queues expected read
// data and samples, a negedge monitor pops and compares them.
module tb_rocketcpu_sample_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

    localparam logic [31:0] A_DATA   = 32'h0000_0000;
    localparam logic [31:0] A_STATUS = 32'h0000_0004;
    localparam logic [31:0] A_CTRL   = 32'h0000_0008;
    localparam logic [31:0] A_RSVD   = 32'h0000_000C;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      i_wb_adr;
    logic [31:0]      i_wb_dat;
    logic [3:0]       i_wb_sel;
    logic             i_wb_we;
    logic             i_wb_cyc;
    logic [31:0]      o_wb_rdt;
    logic             o_wb_ack;
    logic             i_sample_req;
    logic [WIDTH-1:0] o_sample;
    logic             o_irq;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [31:0]      rd_q  [$];
    logic [WIDTH-1:0] smp_q [$];
    logic             req_d = 1'b0;

    always #5 clk = ~clk;

    rocketcpu_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_wb_clk     (clk),
        .reset        (reset),
        .i_wb_adr     (i_wb_adr),
        .i_wb_dat     (i_wb_dat),
        .i_wb_sel     (i_wb_sel),
        .i_wb_we      (i_wb_we),
        .i_wb_cyc     (i_wb_cyc),
        .o_wb_rdt     (o_wb_rdt),
        .o_wb_ack     (o_wb_ack),
        .i_sample_req (i_sample_req),
        .o_sample     (o_sample),
        .o_irq        (o_irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) req_d <= i_sample_req;

    // Monitor: compare read data on every read ack, samples one cycle after each request.
    always @(negedge clk) begin
        if (o_wb_ack && !i_wb_we) begin
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: got 0x%08h with no expected value queued", o_wb_rdt);
            end else begin
                check("rdata", o_wb_rdt, rd_q.pop_front());
            end
        end
        if (req_d) begin
            if (smp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL smp_unexpected: got 0x%04h with no expected value queued", o_sample);
            end else begin
                check("sample", 32'(o_sample), 32'(smp_q.pop_front()));
            end
        end
    end

    task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp);
        @(posedge clk); #1;
        i_wb_adr = adr; i_wb_we = 1'b0; i_wb_dat = 32'd0; i_wb_cyc = 1'b1;
        rd_q.push_back(exp);
        @(posedge clk); #1;
        check("ack_rd", {31'd0, o_wb_ack}, 32'd1);
        @(posedge clk); #1;
        i_wb_cyc = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                            input bit with_req, input logic [WIDTH-1:0] exp_smp);
        @(posedge clk); #1;
        i_wb_adr = adr; i_wb_we = 1'b1; i_wb_dat = dat; i_wb_cyc = 1'b1;
        @(posedge clk); #1;
        check("ack_wr", {31'd0, o_wb_ack}, 32'd1);
        if (with_req) begin
            i_sample_req = 1'b1;
            smp_q.push_back(exp_smp);
        end
        @(posedge clk); #1;
        i_wb_cyc = 1'b0; i_wb_we = 1'b0; i_sample_req = 1'b0;
    endtask

    task automatic pulse_req(input logic [WIDTH-1:0] exp_smp);
        @(posedge clk); #1;
        i_sample_req = 1'b1;
        smp_q.push_back(exp_smp);
        @(posedge clk); #1;
        i_sample_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; i_wb_adr = 32'd0; i_wb_dat = 32'd0; i_wb_sel = 4'hF;
        i_wb_we = 1'b0; i_wb_cyc = 1'b0; i_sample_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_ack", {31'd0, o_wb_ack}, 32'd0);
        check("rst_irq", {31'd0, o_irq}, 32'd0);
        check("rst_sample", 32'(o_sample), 32'd0);
        wb_read(A_STATUS, 32'h0000_0040);
        wb_read(A_CTRL,   32'h0000_0400);

        // Basic streaming
        wb_write(A_CTRL, 32'h0000_0401, 1'b0, '0);
        wb_write(A_DATA, 32'h0000_1234, 1'b0, '0);
        wb_write(A_DATA, 32'h0000_8000, 1'b0, '0);
        wb_write(A_DATA, 32'h0000_7FFF, 1'b0, '0);
        check("irq_lvl3", {31'd0, o_irq}, 32'd1);
        wb_read(A_STATUS, 32'h0000_0003);
        pulse_req(16'h1234);
        check("irq_lvl2", {31'd0, o_irq}, 32'd1);
        pulse_req(16'h8000);
        check("irq_lvl1", {31'd0, o_irq}, 32'd1);
        pulse_req(16'h7FFF);
        check("irq_lvl0", {31'd0, o_irq}, 32'd1);
        wb_read(A_STATUS, 32'h0000_0040);

        // Fill past full while disabled
        wb_write(A_CTRL, 32'h0000_0400, 1'b0, '0);
        check("irq_disabled", {31'd0, o_irq}, 32'd0);
        for (int i = 0; i < 17; i++) begin
            wb_write(A_DATA, 32'h0000_0100 + 32'(i), 1'b0, '0);
        end
        wb_read(A_STATUS, 32'h0000_0130);
        pulse_req(16'h0000);
        wb_read(A_STATUS, 32'h0000_0130);
        wb_write(A_STATUS, 32'h0000_0100, 1'b0, '0);
        wb_read(A_STATUS, 32'h0000_0030);
        wb_read(A_DATA, 32'h0000_0000);
        wb_read(A_RSVD, 32'h0000_0000);

        // Underrun on empty
        wb_write(A_CTRL, 32'h0000_0402, 1'b0, '0);
        wb_read(A_STATUS, 32'h0000_0040);
        wb_write(A_CTRL, 32'h0000_0401, 1'b0, '0);
        pulse_req(16'h0000);
        wb_read(A_STATUS, 32'h0000_00C0);
        wb_write(A_STATUS, 32'h0000_0080, 1'b0, '0);
        wb_read(A_STATUS, 32'h0000_0040);

        // Watermark boundary and simultaneous push/pop at level 5
        for (int i = 1; i <= 4; i++) begin
            wb_write(A_DATA, 32'h0000_A000 + 32'(i), 1'b0, '0);
        end
        check("irq_lvl4_wm4", {31'd0, o_irq}, 32'd1);
        wb_write(A_DATA, 32'h0000_A005, 1'b0, '0);
        check("irq_lvl5_wm4", {31'd0, o_irq}, 32'd0);
        wb_write(A_DATA, 32'h0000_A006, 1'b1, 16'hA001);
        wb_read(A_STATUS, 32'h0000_0005);

        // Flush at level 8
        for (int i = 7; i <= 9; i++) begin
            wb_write(A_DATA, 32'h0000_A000 + 32'(i), 1'b0, '0);
        end
        wb_read(A_STATUS, 32'h0000_0008);
        wb_write(A_CTRL, 32'h0000_0403, 1'b0, '0);
        wb_read(A_STATUS, 32'h0000_0040);
        check("flush_sample_kept", 32'(o_sample), 32'h0000_A001);
        check("flush_irq", {31'd0, o_irq}, 32'd1);
        wb_read(A_CTRL, 32'h0000_0401);

        // Push into empty with a same-cycle pop
        wb_write(A_DATA, 32'h0000_BEEF, 1'b1, 16'h0000);
        wb_read(A_STATUS, 32'h0000_0081);
        pulse_req(16'hBEEF);
        wb_read(A_STATUS, 32'h0000_00C0);

        // Reset in the middle of a transfer
        @(posedge clk); #1;
        i_wb_adr = A_STATUS; i_wb_we = 1'b0; i_wb_cyc = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        check("rst_midxfer_ack", {31'd0, o_wb_ack}, 32'd0);
        i_wb_cyc = 1'b0; reset = 1'b0;
        check("rst2_sample", 32'(o_sample), 32'd0);
        check("rst2_irq", {31'd0, o_irq}, 32'd0);
        wb_read(A_STATUS, 32'h0000_0040);
        wb_read(A_CTRL,   32'h0000_0400);

        repeat (4) @(posedge clk);
        #1;
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("smp_q_drained", 32'(smp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
